// File: rtl/stream_pkg.sv
// Shared types and constants for the stream_gen / stream_check pair.
package stream_pkg;

   localparam int unsigned STREAM_DATA_W = 32;
   localparam int unsigned STREAM_KEEP_W = STREAM_DATA_W / 8;
   localparam logic [STREAM_KEEP_W-1:0] KEEP_ALL = '1;

   // Checker phase: SYNC waits for the first beat to seed the pattern.
   typedef enum logic [0:0] {
      SYNC,
      RUN
   } chk_state_t;

endpackage

// File: rtl/axis_rate_gate.sv
// Registered tready throttle: one acceptance slot per data_rate+1 cycles.
module axis_rate_gate (
   input  logic        clk,
   input  logic        aresetn,
   input  logic [15:0] data_rate,
   input  logic        tvalid,
   output logic        tready
);

   logic [15:0] rate_cnt_q, rate_cnt_d;
   logic        tready_q, tready_d;

   // Next-state: reload on handshake, otherwise count down and open the slot at zero.
   always_comb begin
      rate_cnt_d = rate_cnt_q;
      tready_d   = tready_q;
      if (tready_q && tvalid) begin
         rate_cnt_d = data_rate;
         tready_d   = (data_rate == 16'd0);
      end else if (rate_cnt_q != 16'd0) begin
         rate_cnt_d = rate_cnt_q - 16'd1;
         // Counter reaches zero on this edge, so the slot opens now.
         tready_d   = (rate_cnt_q == 16'd1);
      end else begin
         tready_d = 1'b1;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         rate_cnt_q <= 16'd0;
         tready_q   <= 1'b0;
      end else begin
         rate_cnt_q <= rate_cnt_d;
         tready_q   <= tready_d;
      end
   end

   assign tready = tready_q;

endmodule

// File: rtl/stream_check.sv
// AXI-Stream sink for the MM2S direction: checks an incrementing data pattern and
// frame length, and keeps saturating status counters for software readback.
module stream_check
   import stream_pkg::*;
#(
   parameter int unsigned DATA_W = STREAM_DATA_W,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic [31:0]         frame_size,
   input  logic [15:0]         data_rate,
   input  logic                clear,
   input  logic [DATA_W-1:0]   tdata,
   input  logic [DATA_W/8-1:0] tkeep,
   input  logic                tlast,
   input  logic                tvalid,
   output logic                tready,
   output logic                frame_done,
   output logic [CNT_W-1:0]    frame_count,
   output logic [CNT_W-1:0]    word_err_count,
   output logic [CNT_W-1:0]    len_err_count,
   output logic [31:0]         last_frame_len,
   output logic                err_flag
);

   localparam int unsigned KEEP_W = DATA_W / 8;

   chk_state_t        state_q, state_d;
   logic [DATA_W-1:0] expected_q, expected_d;
   logic [31:0]       beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]  frame_count_q, frame_count_d;
   logic [CNT_W-1:0]  word_err_q, word_err_d;
   logic [CNT_W-1:0]  len_err_q, len_err_d;
   logic [31:0]       last_len_q, last_len_d;
   logic              frame_done_q, frame_done_d;
   logic              err_flag_q, err_flag_d;

   logic              hs;
   logic              keep_ok;
   logic              data_err;
   logic [31:0]       beat_len;

   axis_rate_gate u_rate_gate (
      .clk       (clk),
      .aresetn   (aresetn),
      .data_rate (data_rate),
      .tvalid    (tvalid),
      .tready    (tready)
   );

   if (DATA_W == STREAM_DATA_W) begin : g_keep_pkg
      assign keep_ok = (tkeep == KEEP_ALL);
   end else begin : g_keep_any
      assign keep_ok = (tkeep == {KEEP_W{1'b1}});
   end

   assign hs       = tvalid & tready;
   assign data_err = (state_q == RUN) && (tdata != expected_q);
   // Length of the frame including the current beat, saturating.
   assign beat_len = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 32'd1;

   // Checker FSM, beat tracking and counter next-state; clear overrides everything.
   always_comb begin
      state_d       = state_q;
      expected_d    = expected_q;
      beat_cnt_d    = beat_cnt_q;
      frame_count_d = frame_count_q;
      word_err_d    = word_err_q;
      len_err_d     = len_err_q;
      last_len_d    = last_len_q;
      frame_done_d  = 1'b0;
      err_flag_d    = err_flag_q;

      if (hs) begin
         // Seed, resync and match all leave the pattern pointing one past this beat.
         unique case (state_q)
            SYNC: begin
               expected_d = tdata + DATA_W'(1);
               state_d    = RUN;
            end
            RUN: begin
               expected_d = data_err ? tdata + DATA_W'(1) : expected_q + DATA_W'(1);
            end
            default: state_d = SYNC;
         endcase

         // A beat with both faults counts once.
         if (data_err || !keep_ok) begin
            if (word_err_q != '1) word_err_d = word_err_q + CNT_W'(1);
            err_flag_d = 1'b1;
         end

         if (tlast) begin
            last_len_d   = beat_len;
            beat_cnt_d   = 32'd0;
            frame_done_d = 1'b1;
            if (frame_count_q != '1) frame_count_d = frame_count_q + CNT_W'(1);
            if ((frame_size != 32'd0) && (beat_len != frame_size)) begin
               if (len_err_q != '1) len_err_d = len_err_q + CNT_W'(1);
               err_flag_d = 1'b1;
            end
         end else begin
            beat_cnt_d = beat_len;
         end
      end

      if (clear) begin
         state_d       = SYNC;
         expected_d    = '0;
         beat_cnt_d    = 32'd0;
         frame_count_d = '0;
         word_err_d    = '0;
         len_err_d     = '0;
         last_len_d    = 32'd0;
         frame_done_d  = 1'b0;
         err_flag_d    = 1'b0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q       <= SYNC;
         expected_q    <= '0;
         beat_cnt_q    <= 32'd0;
         frame_count_q <= '0;
         word_err_q    <= '0;
         len_err_q     <= '0;
         last_len_q    <= 32'd0;
         frame_done_q  <= 1'b0;
         err_flag_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         beat_cnt_q    <= beat_cnt_d;
         frame_count_q <= frame_count_d;
         word_err_q    <= word_err_d;
         len_err_q     <= len_err_d;
         last_len_q    <= last_len_d;
         frame_done_q  <= frame_done_d;
         err_flag_q    <= err_flag_d;
      end
   end

   assign frame_done     = frame_done_q;
   assign frame_count    = frame_count_q;
   assign word_err_count = word_err_q;
   assign len_err_count  = len_err_q;
   assign last_frame_len = last_len_q;
   assign err_flag       = err_flag_q;

endmodule

// File: tb/tb_stream_check.sv
// Directed bench for stream_check with a frame scoreboard fed by the stimulus.
module tb_stream_check;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] frame_size;
   logic [15:0] data_rate;
   logic        clear;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast;
   logic        tvalid;
   logic        tready;
   logic        frame_done;
   logic [31:0] frame_count;
   logic [31:0] word_err_count;
   logic [31:0] len_err_count;
   logic [31:0] last_frame_len;
   logic        err_flag;

   typedef struct {
      logic [31:0] len;
      logic [31:0] fc;
      logic [31:0] we;
      logic [31:0] le;
   } frame_exp_t;

   frame_exp_t sb[$];
   int n_assert = 0;
   int n_fail   = 0;
   int pulses   = 0;
   int not_rdy  = 0;

   stream_check dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .frame_size     (frame_size),
      .data_rate      (data_rate),
      .clear          (clear),
      .tdata          (tdata),
      .tkeep          (tkeep),
      .tlast          (tlast),
      .tvalid         (tvalid),
      .tready         (tready),
      .frame_done     (frame_done),
      .frame_count    (frame_count),
      .word_err_count (word_err_count),
      .len_err_count  (len_err_count),
      .last_frame_len (last_frame_len),
      .err_flag       (err_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic clr);
      int w = 0;
      tdata  = d;
      tkeep  = k;
      tlast  = l;
      tvalid = 1'b1;
      clear  = clr;
      forever begin
         @(negedge clk);
         if (tready || w >= 64) break;
         w++;
      end
      check("handshake_wait", {31'd0, tready}, 32'd1);
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic idle(input int n);
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic expect_frame(input logic [31:0] len, input logic [31:0] fc,
                               input logic [31:0] we, input logic [31:0] le);
      frame_exp_t e;
      e.len = len;
      e.fc  = fc;
      e.we  = we;
      e.le  = le;
      sb.push_back(e);
   endtask

   // Scoreboard consumer: every frame_done pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (aresetn && frame_done) begin
         pulses++;
         check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            frame_exp_t e;
            e = sb.pop_front();
            check("done_last_len", last_frame_len, e.len);
            check("done_frame_cnt", frame_count, e.fc);
            check("done_word_err", word_err_count, e.we);
            check("done_len_err", len_err_count, e.le);
         end
      end
      if (aresetn && !tready) not_rdy++;
   end

   initial begin
      int nr0;
      int p0;
      int hs;
      int hs_at[16];

      aresetn    = 1'b0;
      frame_size = 32'd16;
      data_rate  = 16'd0;
      clear      = 1'b0;
      tdata      = 32'd0;
      tkeep      = 4'hF;
      tlast      = 1'b0;
      tvalid     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tready", {31'd0, tready}, 32'd0);
      check("rst_frame_cnt", frame_count, 32'd0);
      check("rst_word_err", word_err_count, 32'd0);
      check("rst_last_len", last_frame_len, 32'd0);
      check("rst_err_flag", {31'd0, err_flag}, 32'd0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      // 1: full rate, two 16-beat frames
      nr0 = not_rdy;
      p0  = pulses;
      expect_frame(32'd16, 32'd1, 32'd0, 32'd0);
      expect_frame(32'd16, 32'd2, 32'd0, 32'd0);
      for (int i = 0; i < 32; i++) send(32'(i), 4'hF, (i % 16) == 15, 1'b0);
      idle(3);
      check("t1_not_ready_cycles", 32'(not_rdy - nr0), 32'd0);
      check("t1_pulses", 32'(pulses - p0), 32'd2);
      check("t1_frame_cnt", frame_count, 32'd2);
      check("t1_word_err", word_err_count, 32'd0);
      check("t1_len_err", len_err_count, 32'd0);
      check("t1_last_len", last_frame_len, 32'd16);

      // 2: data_rate=3 with tvalid held high
      pulse_clear();
      data_rate = 16'd3;
      tdata     = 32'd100;
      tkeep     = 4'hF;
      tlast     = 1'b0;
      tvalid    = 1'b1;
      hs        = 0;
      for (int c = 0; c < 32; c++) begin
         logic took;
         @(negedge clk);
         took = tready;
         if (took && hs < 16) begin
            hs_at[hs] = c;
            hs++;
         end
         @(posedge clk);
         #1;
         if (took) tdata = tdata + 32'd1;
      end
      tvalid    = 1'b0;
      data_rate = 16'd0;
      idle(5);
      check("t2_handshakes", 32'(hs), 32'd8);
      if (hs > 0) check("t2_first_slot", 32'(hs_at[0]), 32'd0);
      for (int k = 1; k < hs; k++) check("t2_gap", 32'(hs_at[k] - hs_at[k-1]), 32'd4);
      check("t2_word_err", word_err_count, 32'd0);

      // 3: skipped value and short frame
      pulse_clear();
      frame_size = 32'd16;
      expect_frame(32'd6, 32'd1, 32'd1, 32'd1);
      send(32'd5, 4'hF, 1'b0, 1'b0);
      send(32'd6, 4'hF, 1'b0, 1'b0);
      send(32'd7, 4'hF, 1'b0, 1'b0);
      send(32'd9, 4'hF, 1'b0, 1'b0);
      send(32'd10, 4'hF, 1'b0, 1'b0);
      send(32'd11, 4'hF, 1'b1, 1'b0);
      idle(2);
      check("t3_word_err", word_err_count, 32'd1);
      check("t3_len_err", len_err_count, 32'd1);
      check("t3_last_len", last_frame_len, 32'd6);
      check("t3_err_flag", {31'd0, err_flag}, 32'd1);

      // 4: pattern wraps through zero, one partial tkeep
      pulse_clear();
      check("t4_cleared_flag", {31'd0, err_flag}, 32'd0);
      frame_size = 32'd4;
      expect_frame(32'd4, 32'd1, 32'd1, 32'd0);
      send(32'hFFFF_FFFE, 4'hF, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
      send(32'h0000_0000, 4'h7, 1'b0, 1'b0);
      send(32'h0000_0001, 4'hF, 1'b1, 1'b0);
      idle(2);
      check("t4_word_err", word_err_count, 32'd1);
      check("t4_len_err", len_err_count, 32'd0);
      check("t4_err_flag", {31'd0, err_flag}, 32'd1);

      // 5: clear on beat 5 of a 16-beat frame
      pulse_clear();
      frame_size = 32'd16;
      for (int i = 0; i < 5; i++) send((i == 1) ? 32'd77 : 32'(i), 4'hF, 1'b0, i == 4);
      check("t5_clr_word_err", word_err_count, 32'd0);
      check("t5_clr_err_flag", {31'd0, err_flag}, 32'd0);
      check("t5_clr_frame_cnt", frame_count, 32'd0);
      expect_frame(32'd11, 32'd1, 32'd0, 32'd1);
      for (int i = 5; i < 16; i++) send(32'(i), 4'hF, i == 15, 1'b0);
      idle(2);
      check("t5_last_len", last_frame_len, 32'd11);
      check("t5_len_err", len_err_count, 32'd1);

      // 6: one-cycle reset in the middle of a frame
      frame_size = 32'd0;
      send(32'd50, 4'hF, 1'b0, 1'b0);
      send(32'd51, 4'hF, 1'b0, 1'b0);
      send(32'd52, 4'hF, 1'b0, 1'b0);
      tvalid  = 1'b0;
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      check("t6_rst_tready", {31'd0, tready}, 32'd0);
      check("t6_rst_frame_cnt", frame_count, 32'd0);
      check("t6_rst_len_err", len_err_count, 32'd0);
      check("t6_rst_last_len", last_frame_len, 32'd0);
      check("t6_rst_err_flag", {31'd0, err_flag}, 32'd0);
      aresetn = 1'b1;
      expect_frame(32'd2, 32'd1, 32'd0, 32'd0);
      send(32'd200, 4'hF, 1'b0, 1'b0);
      send(32'd201, 4'hF, 1'b1, 1'b0);
      idle(2);
      check("t6_word_err", word_err_count, 32'd0);
      check("t6_err_flag", {31'd0, err_flag}, 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
